// File: rtl/seqdiv_pkg.sv
// Shared definitions for the sequential restoring divider: state codes and defaults.
// State codes double as the seven-segment display input.
package seqdiv_pkg;

  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;
  localparam int CW_DEF = 4;

  // Quotient on divide-by-zero is this bit replicated across the full width.
  localparam logic ERR_QUO_BIT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR  = 3'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift a bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW-1:0] rem_i,
  input  logic          bit_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW-1:0] rem_o,
  output logic          q_bit_o
);

  // One extra bit keeps the shifted remainder from overflowing before compare.
  logic [VW:0] trial;

  assign trial   = {rem_i, bit_i};
  assign q_bit_o = (trial >= {1'b0, divisor_i});
  assign rem_o   = q_bit_o ? VW'(trial - {1'b0, divisor_i}) : trial[VW-1:0];

endmodule

// File: rtl/seqdiv16x8.sv
// Sequential restoring divider, one quotient bit per clock; result DW edges after accept.
// start/doneflag level handshake: a new operation needs start low for one edge first.
module seqdiv16x8
  import seqdiv_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reseta,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          doneflag,
  output logic          div_by_zero,
  output logic [2:0]    state_out
);

  state_t        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [VW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;

  logic [VW-1:0] step_rem;
  logic          step_q;

  div_step #(.VW(VW)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[DW-1]),
    .divisor_i (div_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            dvd_d   = dividend;
            div_d   = divisor;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = CW'(DW - 1);
            state_d = ST_CALC;
          end else begin
            quotient_d  = {DW{ERR_QUO_BIT}};
            remainder_d = dividend[VW-1:0];
            state_d     = ST_ERR;
          end
        end
      end
      ST_CALC: begin
        dvd_d = {dvd_q[DW-2:0], 1'b0};
        quo_d = {quo_q[DW-2:0], step_q};
        rem_d = step_rem;
        cnt_d = cnt_q - CW'(1);
        // Final step publishes straight from the step logic so outputs land on this edge.
        if (cnt_q == '0) begin
          quotient_d  = {quo_q[DW-2:0], step_q};
          remainder_d = step_rem;
          state_d     = ST_DONE;
        end
      end
      ST_DONE, ST_ERR: begin
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reseta) begin
      state_q     <= ST_IDLE;
      dvd_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign doneflag    = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign div_by_zero = (state_q == ST_ERR);
  assign state_out   = state_q;

endmodule

// File: tb/tb_seqdiv16x8.sv
// Randomized scoreboard bench for seqdiv16x8 against plain integer division.
module tb_seqdiv16x8;

  logic        clk = 1'b0;
  logic        reseta;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        doneflag;
  logic        div_by_zero;
  logic [2:0]  state_out;

  seqdiv16x8 dut (
    .clk         (clk),
    .reseta      (reseta),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .doneflag    (doneflag),
    .div_by_zero (div_by_zero),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  logic [15:0] last_q;
  logic [7:0]  last_r;
  logic done_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every rising doneflag consumes one expected result.
  always @(negedge clk) begin
    if (reseta) begin
      done_prev = 1'b0;
    end else begin
      if (doneflag && !done_prev) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: doneflag rose with empty scoreboard (cycle %0d)", cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("quotient", {16'h0, quotient}, {16'h0, mon_e.q});
          chk("remainder", {24'h0, remainder}, {24'h0, mon_e.r});
          chk("div_by_zero", {31'h0, div_by_zero}, {31'h0, mon_e.dbz});
          chk("done_state", {29'h0, state_out}, mon_e.dbz ? 32'd3 : 32'd2);
          chk("latency_edges", cyc - mon_e.acc + 1, mon_e.dbz ? 32'd1 : 32'd17);
        end
      end
      done_prev = doneflag;
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        input bit scramble, input int hold_extra);
    exp_t e;
    int n;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (b == 8'd0) begin
      e.q   = 16'hFFFF;
      e.r   = a[7:0];
      e.dbz = 1'b1;
    end else begin
      e.q   = a / {8'h0, b};
      e.r   = 8'(a % {8'h0, b});
      e.dbz = 1'b0;
    end
    @(posedge clk);
    #1;
    e.acc = cyc;
    sbq.push_back(e);
    n = 0;
    @(negedge clk);
    while (!doneflag && n < 40) begin
      chk("calc_state", {29'h0, state_out}, 32'd1);
      chk("calc_hold_q", {16'h0, quotient}, {16'h0, last_q});
      chk("calc_hold_r", {24'h0, remainder}, {24'h0, last_r});
      if (scramble) begin
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
      end
      n++;
      @(negedge clk);
    end
    if (!doneflag) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no doneflag within 40 cycles for %0d/%0d", a, b);
    end
    last_q = e.q;
    last_r = e.r;
    repeat (hold_extra) begin
      @(negedge clk);
      chk("hold_done", {31'h0, doneflag}, 32'd1);
      chk("hold_state", {29'h0, state_out}, (b == 8'd0) ? 32'd3 : 32'd2);
    end
    start = 1'b0;
    @(negedge clk);
    chk("idle_state", {29'h0, state_out}, 32'd0);
    chk("idle_done", {31'h0, doneflag}, 32'd0);
    chk("idle_dbz", {31'h0, div_by_zero}, 32'd0);
    chk("idle_keep_q", {16'h0, quotient}, {16'h0, e.q});
    chk("idle_keep_r", {24'h0, remainder}, {24'h0, e.r});
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_state"}, {29'h0, state_out}, 32'd0);
    chk({tag, "_q"}, {16'h0, quotient}, 32'd0);
    chk({tag, "_r"}, {24'h0, remainder}, 32'd0);
    chk({tag, "_done"}, {31'h0, doneflag}, 32'd0);
    chk({tag, "_dbz"}, {31'h0, div_by_zero}, 32'd0);
  endtask

  task automatic reset_mid_calc();
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    repeat (8) @(negedge clk);
    reseta = 1'b1;
    @(negedge clk);
    check_reset_state("mid_reset");
    reseta = 1'b0;
    start  = 1'b0;
    last_q = 16'h0;
    last_r = 8'h0;
    @(negedge clk);
    chk("post_reset_idle", {29'h0, state_out}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int sel;
    reseta   = 1'b1;
    start    = 1'b0;
    dividend = 16'h0;
    divisor  = 8'h0;
    last_q   = 16'h0;
    last_r   = 8'h0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reseta = 1'b0;

    run_op(16'd1000, 8'd7, 1'b0, 0);
    run_op(16'hFFFF, 8'hFF, 1'b0, 0);
    run_op(16'hFFFF, 8'd1, 1'b0, 0);
    run_op(16'd5, 8'd9, 1'b0, 0);
    run_op(16'd0, 8'd3, 1'b0, 0);
    run_op(16'd100, 8'd0, 1'b0, 2);
    reset_mid_calc();
    run_op(16'd1000, 8'd7, 1'b0, 0);
    run_op(16'd1234, 8'h25, 1'b0, 5);
    run_op(16'd50000, 8'd13, 1'b1, 0);
    run_op(16'd777, 8'd200, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 8'd0;
      else if (sel < 4)  b = 8'($urandom_range(1, 15));
      else               b = 8'($urandom);
      run_op(16'($urandom), b, 1'($urandom), $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seqdiv16x8.md
Name: seqdiv16x8

Overview:
Sequential restoring divider and the inverse of the team's sequential 8x8 multiplier. It divides a 16-bit dividend by an 8-bit divisor, resolving one quotient bit per clock, and returns a 16-bit quotient and an 8-bit remainder. Its start/doneflag handshake and 3-bit state_out match the multiplier, so the divider drops into the same top level with the same seven_segment_encoder for state display.

Parameters:
- DW, default 16, dividend and quotient width.
- VW, default 8, divisor and remainder width.
- CW, default 4, iteration counter width; must satisfy 2^CW >= DW.

Ports:
- clk  input  1  system clock, rising edge.
- reseta  input  1  reset, synchronous, active-high.
- start  input  1  level request; an operation is accepted on a rising edge of clk while in IDLE with start=1.
- dividend  input  DW  numerator; sampled only at the accept edge.
- divisor  input  VW  denominator; sampled only at the accept edge.
- quotient  output  DW  result; registered.
- remainder  output  VW  result; registered.
- doneflag  output  1  high only in DONE or ERR.
- div_by_zero  output  1  high only in ERR.
- state_out  output  3  current state code, for the seven-segment display.

Behaviour:
- Reset (reseta=1 at a clk edge):
  - state goes to IDLE; quotient, remainder, internal registers and counter go to 0.
  - doneflag=0, div_by_zero=0, state_out=3'd0.
  - Reset has priority over all events and aborts an in-flight CALC with no partial result kept.
- State codes: IDLE=0, CALC=1, DONE=2, ERR=3; codes 4-7 are unused and recover to IDLE on the next edge.
- IDLE:
  - start=1 and divisor!=0: latch dividend into the shift register, latch divisor, clear the partial remainder, set count=DW-1, go to CALC.
  - start=1 and divisor==0: go to ERR; load quotient=all-ones and remainder=dividend[VW-1:0].
  - start=0: stay in IDLE.
- CALC, one step per edge:
  - Form a (VW+1)-bit trial value: the partial remainder shifted left by one, with the dividend register MSB shifted in as the new LSB.
  - If trial >= divisor: new partial remainder = trial - divisor, and shift 1 into the quotient register LSB.
  - Otherwise: new partial remainder = trial, and shift 0 into the quotient register LSB.
  - Shift the dividend register left by one.
  - The width is VW+1 bits so the trial never overflows.
- CALC termination:
  - Steps that reach count=0 and complete: go to DONE, and copy the quotient and remainder registers to the outputs on that same edge.
  - Latency: exactly DW CALC edges after the accept edge. doneflag rises after edge DW+1, counting the accept edge as edge 1.
- Outputs stay stable throughout CALC: quotient/remainder hold the previous result and change only on the completing edge or on entry to ERR.
- start is ignored while in CALC; dropping it does not abort.
- DONE/ERR:
  - Hold outputs while start=1.
  - start=0: go to IDLE; doneflag and div_by_zero clear, quotient/remainder keep their values.
  - A new operation requires start low for at least one edge, then high.
- dividend and divisor may change freely after the accept edge without affecting the result.

Decomposition:
- Shared package seqdiv_pkg holds:
  - the state enum: IDLE, CALC, DONE, ERR as 3-bit codes 0-3 (matching the seven_segment_encoder input);
  - DW, VW and CW defaults;
  - the quotient value returned on ERR (all-ones).
- One natural sub-module, div_step: the combinational restoring step.
  - Inputs: partial remainder, incoming bit, divisor.
  - Outputs: next partial remainder, quotient bit.
- The controller FSM, counter and datapath registers stay in seqdiv16x8.

Test Plan:
- Reset, then dividend=16'd1000, divisor=8'd7, start pulse held → doneflag after edge 17; quotient=16'h008E (142), remainder=8'd6, div_by_zero=0; state_out sequence 0,1×16,2.
- dividend=16'hFFFF, divisor=8'hFF → quotient=16'h0101, remainder=0. dividend=16'hFFFF, divisor=1 → quotient=16'hFFFF, remainder=0.
- dividend=16'd5, divisor=8'd9 → quotient=0, remainder=5. dividend=0, divisor=8'd3 → quotient=0, remainder=0.
- dividend=16'd100, divisor=0 → ERR one edge after accept; doneflag=1, div_by_zero=1, quotient=16'hFFFF, remainder=8'd100, state_out=3. start low → IDLE with both flags cleared.
- Assert reseta at CALC step 8 → next edge: IDLE, outputs 0. Re-issue 1000/7 → correct result.
- Hold start high after DONE → no second operation. Change dividend/divisor mid-CALC → result unchanged. Toggle start low-high → next operation runs with the new operands.
